uzorak_punjac: RTL and testbench
================================

Name: uzorak_punjac

Overview:
- Producer side of the 960-bit `uzorak` sample bus read by the neuron layer.
- Receives one 16-bit sign-magnitude feature word per handshake and packs BROJ_ULAZA words into the flat sample bus.
- Presents the full bus with a valid/ready handshake and holds it stable until the neuron-layer controller accepts it.
- Sits between the sonar-feature source (UART/ROM reader) and the first neuron layer.

Parameters:
- BROJ_ULAZA, 60, number of feature words per sample; legal range 2..255.
- SIRINA, 16, word width; bit SIRINA-1 is the sign, the low bits are the magnitude.
- SIRINA_BROJACA, 8, width of the frame counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ulaz_podatak  input  SIRINA  incoming feature word.
- ulaz_valid  input  1  ulaz_podatak is valid.
- ulaz_sof  input  1  start of frame; meaningful only when ulaz_valid=1.
- ulaz_ready  output  1  block can accept a word.
- uzorak  output  BROJ_ULAZA*SIRINA  packed sample; word k occupies bits [16k+15:16k].
- uzorak_valid  output  1  uzorak is complete and stable.
- uzorak_ready  input  1  consumer accepts uzorak.
- broj_okvira  output  SIRINA_BROJACA  count of delivered samples.
- greska  output  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - state SKUPLJANJE, index idx=0;
  - uzorak=0, uzorak_valid=0, broj_okvira=0, greska=0.
- ulaz_ready = !rst && state==SKUPLJANJE. It is combinational from state; there is no combinational path from ulaz_valid.
- A word is accepted on a rising edge where ulaz_valid && ulaz_ready.
- Accepted word without sof: written to slot idx, then idx increments.
- Accepted word with sof:
  - written to slot 0 and idx becomes 1;
  - if idx was not 0, greska=1 for exactly the next cycle;
  - stale slots are not cleared, only overwritten later.
- The first frame after reset or after delivery needs no sof.
- Frame completion: when the word written is slot BROJ_ULAZA-1:
  - state becomes PUNO and uzorak_valid=1 from the next cycle;
  - latency is 1 cycle from the last accepted word to valid.
  - sof on the final word of a frame is illegal if BROJ_ULAZA>1. sof always wins: the word goes to slot 0.
- PUNO state:
  - ulaz_ready=0; uzorak and uzorak_valid are held unchanged regardless of ulaz_*.
  - On an edge with uzorak_ready=1: state becomes SKUPLJANJE, uzorak_valid=0, idx=0, broj_okvira increments (wraps modulo 2^SIRINA_BROJACA).
  - uzorak keeps its old content after acceptance; the next frame overwrites it word by word.
- uzorak_ready high in SKUPLJANJE has no effect.
- No word can be accepted in the same cycle as delivery (ulaz_ready is 0 in PUNO). Peak throughput is BROJ_ULAZA+1 cycles per sample.
- ulaz_valid gaps of any length in SKUPLJANJE are allowed; idx holds.
- Reset mid-frame or in PUNO: the partial or pending sample is lost, all outputs return to reset values, and greska is not pulsed.
- No arithmetic on data in the default build: words are stored bit-exact. The sign-magnitude -0 (16'h8000) is stored as given.

Optional Feature:
- Macro: UZORAK_DVOJNI_KOMPLEMENT_EN.
- Defined: ulaz_podatak is treated as two's complement and converted before storage:
  - non-negative values pass unchanged;
  - negative values become sign=1, magnitude = -value;
  - 16'h8000 (-32768) saturates to 16'hFFFF (sign 1, magnitude 32767).
- Not defined: words are stored bit-exact as sign-magnitude.

Test Plan:
- Feed 60 back-to-back words 16'd1..16'd60 with uzorak_ready=0 → after the 60th, uzorak_valid=1 one cycle later, uzorak[15:0]=1, uzorak[959:944]=60, ulaz_ready=0.
- Hold uzorak_ready=0 for 20 cycles with ulaz_valid=1 and changing data → uzorak unchanged. Pulse uzorak_ready for 1 cycle → uzorak_valid=0 next cycle, broj_okvira=1, ulaz_ready=1.
- Send 30 words, then a sof word 16'hABCD followed by 59 words → greska pulses once on the cycle after the sof word, uzorak[15:0]=16'hABCD, broj_okvira increments once.
- Assert rst asynchronously (mid-cycle) after 45 words → uzorak=0 and uzorak_valid=0 immediately. A full 60-word frame after release → valid after 60 words, not 15.
- Deliver 256 frames with random ulaz_valid gaps → broj_okvira wraps 255→0, and every frame's data matches the reference model.
- With UZORAK_DVOJNI_KOMPLEMENT_EN defined: inputs 16'hFFFF, 16'h8000, 16'h0005 → stored as 16'h8001, 16'hFFFF, 16'h0005.

Source files
------------

// File: rtl/uzorak_punjac.sv
//------------------------------------------------------------------------------
// Module   : uzorak_punjac
// Purpose  : Packs BROJ_ULAZA feature words into the flat uzorak bus and hands
//            it to the neuron layer over a valid/ready handshake.
//            Optional macro UZORAK_DVOJNI_KOMPLEMENT_EN converts two's-complement
//            input words to sign-magnitude before storage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uzorak_punjac #(
  parameter int BROJ_ULAZA     = 60,
  parameter int SIRINA         = 16,
  parameter int SIRINA_BROJACA = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SIRINA-1:0]            ulaz_podatak,
  input  logic                         ulaz_valid,
  input  logic                         ulaz_sof,
  output logic                         ulaz_ready,
  output logic [BROJ_ULAZA*SIRINA-1:0] uzorak,
  output logic                         uzorak_valid,
  input  logic                         uzorak_ready,
  output logic [SIRINA_BROJACA-1:0]    broj_okvira,
  output logic                         greska
);

  localparam int c_IDX_W = $clog2(BROJ_ULAZA);

  typedef enum logic [0:0] {
    SKUPLJANJE = 1'b0,
    PUNO       = 1'b1
  } stanje_t;

  stanje_t              r_stanje;
  logic [c_IDX_W-1:0]   r_idx;
  logic [SIRINA-1:0]    w_rijec;
  logic                 w_prihvat;
  logic [c_IDX_W-1:0]   w_slot;
  logic                 w_zadnji;

  assign ulaz_ready = !rst && (r_stanje == SKUPLJANJE);
  assign w_prihvat  = ulaz_valid && (r_stanje == SKUPLJANJE);
  // sof always wins, even on what would have been the last slot
  assign w_slot     = ulaz_sof ? '0 : r_idx;
  assign w_zadnji   = !ulaz_sof && (r_idx == c_IDX_W'(BROJ_ULAZA - 1));

`ifdef UZORAK_DVOJNI_KOMPLEMENT_EN
  logic [SIRINA-1:0] w_neg;
  assign w_neg = (~ulaz_podatak) + SIRINA'(1);

  always_comb begin
    w_rijec = ulaz_podatak;
    if (ulaz_podatak[SIRINA-1]) begin
      // most negative value has no magnitude in range, saturate it
      if (ulaz_podatak[SIRINA-2:0] == '0)
        w_rijec = '1;
      else
        w_rijec = {1'b1, w_neg[SIRINA-2:0]};
    end
  end
`else
  assign w_rijec = ulaz_podatak;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stanje     <= SKUPLJANJE;
      r_idx        <= '0;
      uzorak       <= '0;
      uzorak_valid <= 1'b0;
      broj_okvira  <= '0;
      greska       <= 1'b0;
    end else begin
      greska <= 1'b0;
      for (int k = 0; k < BROJ_ULAZA; k++) begin
        if (w_prihvat && (w_slot == c_IDX_W'(k)))
          uzorak[k*SIRINA +: SIRINA] <= w_rijec;
      end
      case (r_stanje)
        SKUPLJANJE: begin
          if (ulaz_valid) begin
            if (ulaz_sof) begin
              r_idx  <= c_IDX_W'(1);
              greska <= (r_idx != '0);
            end else if (w_zadnji) begin
              r_idx        <= '0;
              r_stanje     <= PUNO;
              uzorak_valid <= 1'b1;
            end else begin
              r_idx <= r_idx + c_IDX_W'(1);
            end
          end
        end
        PUNO: begin
          if (uzorak_ready) begin
            r_stanje     <= SKUPLJANJE;
            uzorak_valid <= 1'b0;
            r_idx        <= '0;
            broj_okvira  <= broj_okvira + SIRINA_BROJACA'(1);
          end
        end
        default: r_stanje <= SKUPLJANJE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uzorak_punjac.sv
//------------------------------------------------------------------------------
// Module   : tb_uzorak_punjac
// Purpose  : Directed self-checking bench for uzorak_punjac.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uzorak_punjac;

  localparam int N = 60;
  localparam int W = 16;
  localparam int C = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   ulaz_podatak;
  logic           ulaz_valid;
  logic           ulaz_sof;
  logic           ulaz_ready;
  logic [N*W-1:0] uzorak;
  logic           uzorak_valid;
  logic           uzorak_ready;
  logic [C-1:0]   broj_okvira;
  logic           greska;

  int n_checks = 0;
  int n_errors = 0;
  int greska_cnt = 0;
  logic [N*W-1:0] exp_uz;

  uzorak_punjac #(.BROJ_ULAZA(N), .SIRINA(W), .SIRINA_BROJACA(C)) dut (
    .clk(clk), .rst(rst), .ulaz_podatak(ulaz_podatak), .ulaz_valid(ulaz_valid),
    .ulaz_sof(ulaz_sof), .ulaz_ready(ulaz_ready), .uzorak(uzorak),
    .uzorak_valid(uzorak_valid), .uzorak_ready(uzorak_ready),
    .broj_okvira(broj_okvira), .greska(greska)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (greska === 1'b1) greska_cnt++;

  // Stimulus helpers: every task starts and ends at posedge+1
  task automatic send_word(input logic [W-1:0] d, input logic s);
    ulaz_podatak = d; ulaz_sof = s; ulaz_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic deliver();
    ulaz_valid = 1'b0; uzorak_ready = 1'b1;
    @(posedge clk); #1;
    uzorak_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ulaz_valid = 1'b0; ulaz_sof = 1'b0; ulaz_podatak = '0; uzorak_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (uzorak !== '0) begin n_errors++; $display("FAIL reset_uzorak: got %h, expected 0", uzorak); end
    n_checks++; if (uzorak_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b, expected 0", uzorak_valid); end
    n_checks++; if (broj_okvira !== 8'd0) begin n_errors++; $display("FAIL reset_broj: got %0d, expected 0", broj_okvira); end
    n_checks++; if (greska !== 1'b0) begin n_errors++; $display("FAIL reset_greska: got %b, expected 0", greska); end
    n_checks++; if (ulaz_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready_in_rst: got %b, expected 0", ulaz_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ulaz_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready_after: got %b, expected 1", ulaz_ready); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < N; k++) begin
      send_word(W'(k + 1), 1'b0);
      exp_uz[k*W +: W] = W'(k + 1);
      if (k == N - 2) begin
        n_checks++; if (uzorak_valid !== 1'b0) begin n_errors++; $display("FAIL fill_early_valid: got %b, expected 0", uzorak_valid); end
      end
    end
    ulaz_valid = 1'b0;
    n_checks++; if (uzorak_valid !== 1'b1) begin n_errors++; $display("FAIL fill_valid: got %b, expected 1", uzorak_valid); end
    n_checks++; if (uzorak[15:0] !== 16'd1) begin n_errors++; $display("FAIL fill_slot0: got %h, expected 0001", uzorak[15:0]); end
    n_checks++; if (uzorak[959:944] !== 16'd60) begin n_errors++; $display("FAIL fill_slot59: got %h, expected 003c", uzorak[959:944]); end
    n_checks++; if (ulaz_ready !== 1'b0) begin n_errors++; $display("FAIL fill_ready: got %b, expected 0", ulaz_ready); end
    n_checks++; if (uzorak !== exp_uz) begin n_errors++; $display("FAIL fill_data: got %h, expected %h", uzorak, exp_uz); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 20; i++) begin
      send_word(W'($urandom), 1'(i));
      n_checks++; if (uzorak !== exp_uz || uzorak_valid !== 1'b1) begin
        n_errors++; $display("FAIL hold_cycle%0d: got valid=%b %h, expected valid=1 %h", i, uzorak_valid, uzorak, exp_uz);
      end
    end
    deliver();
    n_checks++; if (uzorak_valid !== 1'b0) begin n_errors++; $display("FAIL hold_accept_valid: got %b, expected 0", uzorak_valid); end
    n_checks++; if (broj_okvira !== 8'd1) begin n_errors++; $display("FAIL hold_accept_broj: got %0d, expected 1", broj_okvira); end
    n_checks++; if (ulaz_ready !== 1'b1) begin n_errors++; $display("FAIL hold_accept_ready: got %b, expected 1", ulaz_ready); end
    n_checks++; if (uzorak !== exp_uz) begin n_errors++; $display("FAIL hold_keep_data: got %h, expected %h", uzorak, exp_uz); end
  endtask

  task automatic test_sof_discard();
    greska_cnt = 0;
    for (int k = 0; k < 30; k++) send_word(W'(16'h0100 + k), 1'b0);
    send_word(16'hABCD, 1'b1);
    exp_uz[0 +: W] = 16'hABCD;
    n_checks++; if (greska !== 1'b1) begin n_errors++; $display("FAIL sof_greska_pulse: got %b, expected 1", greska); end
    for (int k = 1; k < N; k++) begin
      send_word(W'(16'h0200 + k), 1'b0);
      exp_uz[k*W +: W] = W'(16'h0200 + k);
      if (k == 1) begin
        n_checks++; if (greska !== 1'b0) begin n_errors++; $display("FAIL sof_greska_end: got %b, expected 0", greska); end
      end
      if (k == N - 2) begin
        n_checks++; if (uzorak_valid !== 1'b0) begin n_errors++; $display("FAIL sof_early_valid: got %b, expected 0", uzorak_valid); end
      end
    end
    ulaz_valid = 1'b0;
    n_checks++; if (uzorak_valid !== 1'b1) begin n_errors++; $display("FAIL sof_valid: got %b, expected 1", uzorak_valid); end
    n_checks++; if (uzorak !== exp_uz) begin n_errors++; $display("FAIL sof_data: got %h, expected %h", uzorak, exp_uz); end
    n_checks++; if (greska_cnt !== 1) begin n_errors++; $display("FAIL sof_greska_count: got %0d, expected 1", greska_cnt); end
    deliver();
    n_checks++; if (broj_okvira !== 8'd2) begin n_errors++; $display("FAIL sof_broj: got %0d, expected 2", broj_okvira); end
  endtask

  task automatic test_async_reset();
    greska_cnt = 0;
    for (int k = 0; k < 45; k++) send_word(W'(16'h0300 + k), 1'b0);
    ulaz_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (uzorak !== '0) begin n_errors++; $display("FAIL arst_uzorak: got %h, expected 0", uzorak); end
    n_checks++; if (uzorak_valid !== 1'b0 || ulaz_ready !== 1'b0) begin
      n_errors++; $display("FAIL arst_flags: got valid=%b ready=%b, expected 0 0", uzorak_valid, ulaz_ready);
    end
    n_checks++; if (broj_okvira !== 8'd0) begin n_errors++; $display("FAIL arst_broj: got %0d, expected 0", broj_okvira); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    // uzorak_ready held high while gathering must not deliver anything
    uzorak_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) uzorak_ready = 1'b0;
      send_word(W'(16'h0400 + k), 1'b0);
      exp_uz[k*W +: W] = W'(16'h0400 + k);
      if (k == 14 || k == N - 2) begin
        n_checks++; if (uzorak_valid !== 1'b0 || broj_okvira !== 8'd0) begin
          n_errors++; $display("FAIL arst_refill_k%0d: got valid=%b broj=%0d, expected 0 0", k, uzorak_valid, broj_okvira);
        end
      end
    end
    ulaz_valid = 1'b0;
    n_checks++; if (uzorak_valid !== 1'b1) begin n_errors++; $display("FAIL arst_refill_valid: got %b, expected 1", uzorak_valid); end
    n_checks++; if (uzorak !== exp_uz) begin n_errors++; $display("FAIL arst_refill_data: got %h, expected %h", uzorak, exp_uz); end
    n_checks++; if (greska_cnt !== 0) begin n_errors++; $display("FAIL arst_no_greska: got %0d, expected 0", greska_cnt); end
    deliver();
    n_checks++; if (broj_okvira !== 8'd1) begin n_errors++; $display("FAIL arst_broj_after: got %0d, expected 1", broj_okvira); end
  endtask

  task automatic test_conversion();
    logic [W-1:0] e0, e1;
`ifdef UZORAK_DVOJNI_KOMPLEMENT_EN
    e0 = 16'h8001; e1 = 16'hFFFF;
`else
    e0 = 16'hFFFF; e1 = 16'h8000;
`endif
    send_word(16'hFFFF, 1'b0);
    send_word(16'h8000, 1'b0);
    send_word(16'h0005, 1'b0);
    for (int k = 3; k < N; k++) send_word(16'h0000, 1'b0);
    ulaz_valid = 1'b0;
    n_checks++; if (uzorak[15:0] !== e0) begin n_errors++; $display("FAIL conv_ffff: got %h, expected %h", uzorak[15:0], e0); end
    n_checks++; if (uzorak[31:16] !== e1) begin n_errors++; $display("FAIL conv_8000: got %h, expected %h", uzorak[31:16], e1); end
    n_checks++; if (uzorak[47:32] !== 16'h0005) begin n_errors++; $display("FAIL conv_0005: got %h, expected 0005", uzorak[47:32]); end
    deliver();
  endtask

  task automatic test_wrap();
    logic [W-1:0] d;
    rst = 1'b1; #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < N; k++) begin
        while ($urandom_range(0, 3) == 0) begin
          ulaz_valid = 1'b0; ulaz_podatak = W'($urandom);
          @(posedge clk); #1;
        end
        d = W'($urandom);
        send_word(d, 1'b0);
        exp_uz[k*W +: W] = d;
      end
      ulaz_valid = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(posedge clk); #1;
      end
      n_checks++; if (uzorak_valid !== 1'b1 || uzorak !== exp_uz) begin
        n_errors++; $display("FAIL wrap_frame%0d: got valid=%b %h, expected valid=1 %h", f, uzorak_valid, uzorak, exp_uz);
      end
      deliver();
      n_checks++; if (broj_okvira !== C'(f + 1)) begin
        n_errors++; $display("FAIL wrap_broj%0d: got %0d, expected %0d", f, broj_okvira, C'(f + 1));
      end
    end
    n_checks++; if (broj_okvira !== 8'd0) begin n_errors++; $display("FAIL wrap_final: got %0d, expected 0", broj_okvira); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_hold();
    test_sof_discard();
    test_async_reset();
    test_conversion();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
